// File: rtl/i2c_ioexp_sched.sv
// Schedules writes and reads for two 16-bit I2C IO expanders over a single
// command/response I2C engine, using round-robin arbitration over four slots.
module i2c_ioexp_sched #(
    parameter logic [6:0] DEV0_ADDR = 7'h20,
    parameter logic [6:0] DEV1_ADDR = 7'h21,
    parameter int         POLL_BITS = 20,
    parameter int         TO_BITS   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] out0,
    input  logic [15:0] out1,
    input  logic        irq0,
    input  logic        irq1,
    output logic [15:0] in0,
    output logic [15:0] in1,
    output logic        in0_upd,
    output logic        in1_upd,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [6:0]  cmd_addr,
    output logic        cmd_rw,
    output logic [15:0] cmd_data,
    input  logic        rsp_valid,
    input  logic        rsp_err,
    input  logic [15:0] rsp_data,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

    // Slot encoding: bit 1 selects the device, bit 0 selects read.
    localparam logic [1:0]         SLOT_R1 = 2'd3;
    localparam logic [TO_BITS-1:0] TO_LAST = {{(TO_BITS-1){1'b1}}, 1'b0};

    state_t               state, state_next;
    logic [15:0]          shadow0, shadow1;
    logic [1:0]           rd_pend, rd_set, rd_clr, irq_q;
    logic [POLL_BITS-1:0] poll_cnt;
    logic                 poll_tick;
    logic [1:0]           rr_ptr, cur_slot, gnt_slot, cand;
    logic [TO_BITS-1:0]   to_cnt;
    logic [3:0]           pend;
    logic                 found, grant, rsp_done, timeout, xfer_end, xfer_ok;

    assign pend = {rd_pend[1], out1 != shadow1, rd_pend[0], out0 != shadow0};

    // Search starts at the slot after the last grant and wraps once round.
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        found    = 1'b0;
        gnt_slot = rr_ptr;
        cand     = rr_ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!found && pend[cand]) begin
                found    = 1'b1;
                gnt_slot = cand;
            end
        end
    end

    assign grant    = (state == IDLE) && en && found;
    assign rsp_done = (state == WAIT) && rsp_valid;
    assign timeout  = (state == WAIT) && !rsp_valid && (to_cnt == TO_LAST);
    assign xfer_end = rsp_done || timeout;
    assign xfer_ok  = rsp_done && !rsp_err;
    assign rd_set   = ({irq1, irq0} & ~irq_q) | {2{poll_tick}};
    assign rd_clr   = {grant && (gnt_slot == 2'd3), grant && (gnt_slot == 2'd1)};

    always_comb begin
        state_next = state;
        cmd_valid  = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE:  if (grant) state_next = ISSUE;
            ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready) state_next = WAIT;
            end
            WAIT:  if (xfer_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            to_cnt <= '0;
        end else begin
            state  <= state_next;
            to_cnt <= (state == WAIT) ? to_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            poll_cnt  <= '0;
            poll_tick <= 1'b0;
            irq_q     <= 2'b00;
            rd_pend   <= 2'b11;
        end else begin
            poll_cnt  <= poll_cnt + 1'b1;
            poll_tick <= &poll_cnt;
            irq_q     <= {irq1, irq0};
            // Cleared at grant so any set event during the read leaves it re-armed.
            rd_pend   <= (rd_pend & ~rd_clr) | rd_set;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= SLOT_R1;
            cur_slot <= 2'd0;
            cmd_addr <= '0;
            cmd_rw   <= 1'b0;
            cmd_data <= '0;
        end else if (grant) begin
            rr_ptr   <= gnt_slot;
            cur_slot <= gnt_slot;
            cmd_addr <= gnt_slot[1] ? DEV1_ADDR : DEV0_ADDR;
            cmd_rw   <= gnt_slot[0];
            cmd_data <= gnt_slot[0] ? 16'h0000 : (gnt_slot[1] ? out1 : out0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow0 <= '0;
            shadow1 <= '0;
            in0     <= '0;
            in1     <= '0;
            in0_upd <= 1'b0;
            in1_upd <= 1'b0;
            err_cnt <= '0;
        end else begin
            in0_upd <= 1'b0;
            in1_upd <= 1'b0;
            if (xfer_ok) begin
                unique case (cur_slot)
                    2'd0: shadow0 <= cmd_data;
                    2'd1: begin in0 <= rsp_data; in0_upd <= 1'b1; end
                    2'd2: shadow1 <= cmd_data;
                    default: begin in1 <= rsp_data; in1_upd <= 1'b1; end
                endcase
            end
            if (xfer_end && !xfer_ok && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_i2c_ioexp_sched.sv
// Bench for i2c_ioexp_sched: directed transaction table, hand-written corner
// sequences, then randomized traffic against a slot-level reference model.
module tb_i2c_ioexp_sched;

    localparam int PB     = 10;
    localparam int PERIOD = 1 << PB;

    logic        clk = 1'b0, reset = 1'b0, en = 1'b0;
    logic [15:0] out0 = '0, out1 = '0;
    logic        irq0 = 1'b0, irq1 = 1'b0;
    logic        cmd_ready = 1'b0, rsp_valid = 1'b0, rsp_err = 1'b0;
    logic [15:0] rsp_data = '0;
    logic [15:0] in0, in1, cmd_data;
    logic        in0_upd, in1_upd, cmd_valid, cmd_rw, busy;
    logic [6:0]  cmd_addr;
    logic [7:0]  err_cnt;

    i2c_ioexp_sched #(.DEV0_ADDR(7'h20), .DEV1_ADDR(7'h21), .POLL_BITS(PB), .TO_BITS(6)) dut (
        .clk(clk), .reset(reset), .en(en), .out0(out0), .out1(out1), .irq0(irq0), .irq1(irq1),
        .in0(in0), .in1(in1), .in0_upd(in0_upd), .in1_upd(in1_upd),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_rw(cmd_rw),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int total = 0, bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: slot-level view of what should be pending and produced.
    logic [15:0] m_sh [2];
    logic [15:0] m_in [2];
    bit          m_rf [2];
    int          m_tg [2];
    int          m_last, m_err;

    function automatic logic [15:0] outv(input int n);
        return (n == 1) ? out1 : out0;
    endfunction

    function automatic bit slot_pend(input int s);
        int n = s / 2;
        if (s % 2 == 0) return outv(n) != m_sh[n];
        return m_rf[n] || ((cyc >> PB) > m_tg[n]);
    endfunction

    function automatic int predict();
        for (int k = 1; k <= 4; k++)
            if (slot_pend((m_last + k) % 4)) return (m_last + k) % 4;
        return -1;
    endfunction

    function automatic bit near_tick();
        int m = cyc % PERIOD;
        return (m < 8) || (m > PERIOD - 8);
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_sh[n] = '0; m_in[n] = '0; m_rf[n] = 1'b1; m_tg[n] = 0;
        end
        m_last = 3;
        m_err  = 0;
    endtask

    task automatic model_grant(input int s);
        m_last = s;
        if (s % 2 == 1) begin
            m_rf[s/2] = 1'b0;
            m_tg[s/2] = cyc >> PB;
        end
    endtask

    task automatic model_done(input int s, input logic [15:0] wdata, input logic [15:0] rdata, input bit e);
        if (e) begin
            if (m_err < 255) m_err++;
        end else if (s % 2 == 1) m_in[s/2] = rdata;
        else m_sh[s/2] = wdata;
    endtask

    task automatic wait_valid(input int limit, output bit got);
        int n = 0;
        while (!cmd_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        got = cmd_valid;
        check("cmd_appears", cmd_valid, 1'b1);
    endtask

    task automatic accept(input int rdy_dly);
        logic [23:0] pl;
        pl = {cmd_addr, cmd_rw, cmd_data};
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            check("valid_hold", cmd_valid, 1'b1);
            check("payload_hold", {cmd_addr, cmd_rw, cmd_data}, pl);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("valid_drop", cmd_valid, 1'b0);
    endtask

    task automatic respond(input bit e, input logic [15:0] d);
        rsp_valid = 1'b1;
        rsp_err   = e;
        rsp_data  = d;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
    endtask

    typedef struct {
        bit set0; logic [15:0] v0; bit set1; logic [15:0] v1; int rdy; bit err; logic [15:0] rd;
        logic [6:0] ea; bit erw; logic [15:0] ed; logic [15:0] ei0; logic [15:0] ei1; int eerr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          got, e;
        int          s, n, r;
        logic [15:0] wd, rd;

        vecs[0] = '{0, 16'h0, 1, 16'h1234, 10, 0, 16'h0,    7'h20, 0, 16'hFF00, 16'h0,    16'h0,    0};
        vecs[1] = '{0, 16'h0, 0, 16'h0,     0, 0, 16'hAA55, 7'h20, 1, 16'h0,    16'hAA55, 16'h0,    0};
        vecs[2] = '{0, 16'h0, 0, 16'h0,     1, 0, 16'h0,    7'h21, 0, 16'h1234, 16'hAA55, 16'h0,    0};
        vecs[3] = '{0, 16'h0, 0, 16'h0,     2, 0, 16'h0F0F, 7'h21, 1, 16'h0,    16'hAA55, 16'h0F0F, 0};
        vecs[4] = '{1, 16'h1, 0, 16'h0,     0, 1, 16'h0,    7'h20, 0, 16'h0001, 16'hAA55, 16'h0F0F, 1};
        vecs[5] = '{0, 16'h0, 0, 16'h0,     0, 0, 16'h0,    7'h20, 0, 16'h0001, 16'hAA55, 16'h0F0F, 1};

        out0 = 16'hFF00;
        out1 = 16'h0000;
        en   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_payload", {cmd_addr, cmd_rw, cmd_data}, 24'h0);
        check("rst_in", {in0, in1, in0_upd, in1_upd}, 34'h0);
        check("rst_err_busy", {err_cnt, busy}, 9'h0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].set0) out0 = vecs[i].v0;
            wait_valid(12, got);
            check($sformatf("v%0d_addr", i), cmd_addr, vecs[i].ea);
            check($sformatf("v%0d_rw", i), cmd_rw, vecs[i].erw);
            check($sformatf("v%0d_data", i), cmd_data, vecs[i].ed);
            accept(vecs[i].rdy);
            if (vecs[i].set1) out1 = vecs[i].v1;
            repeat (3) @(negedge clk);
            respond(vecs[i].err, vecs[i].rd);
            check($sformatf("v%0d_in0", i), in0, vecs[i].ei0);
            check($sformatf("v%0d_in1", i), in1, vecs[i].ei1);
            check($sformatf("v%0d_err", i), err_cnt, vecs[i].eerr);
            check($sformatf("v%0d_idle_gap", i), busy, 1'b0);
            check($sformatf("v%0d_upd0", i), in0_upd, vecs[i].erw && vecs[i].ea == 7'h20 && !vecs[i].err);
            check($sformatf("v%0d_upd1", i), in1_upd, vecs[i].erw && vecs[i].ea == 7'h21 && !vecs[i].err);
            @(negedge clk);
            check($sformatf("v%0d_upd_clear", i), {in0_upd, in1_upd}, 2'b00);
        end

        // No response at all: timeout after 63 WAIT cycles counts as an error.
        out1 = 16'h5555;
        wait_valid(12, got);
        check("to_cmd", {cmd_addr, cmd_rw, cmd_data}, {7'h21, 1'b0, 16'h5555});
        accept(0);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("to_wait_cycles", n, 63);
        check("to_err_cnt", err_cnt, 2);

        // Retry of the timed-out write, with en dropped while it is in flight.
        wait_valid(12, got);
        check("retry_cmd", {cmd_addr, cmd_rw, cmd_data}, {7'h21, 1'b0, 16'h5555});
        accept(0);
        en = 1'b0;
        respond(1'b0, 16'h0);
        out0 = 16'h7777;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (cmd_valid) n++;
        end
        check("en_low_no_grant", n, 0);
        en = 1'b1;
        wait_valid(5, got);
        check("en_high_cmd", {cmd_addr, cmd_rw, cmd_data}, {7'h20, 1'b0, 16'h7777});
        accept(0);
        respond(1'b0, 16'h0);

        // A response outside WAIT is ignored.
        respond(1'b1, 16'hDEAD);
        check("stray_rsp_err", err_cnt, 2);
        check("stray_rsp_in0", {in0, in0_upd, in1_upd}, {16'hAA55, 2'b00});
        check("stray_rsp_busy", busy, 1'b0);

        // Reset in the middle of a command aborts immediately.
        out1 = 16'h9999;
        wait_valid(12, got);
        reset = 1'b0;
        #1;
        check("midrst_valid", cmd_valid, 1'b0);
        check("midrst_payload", {cmd_addr, cmd_rw, cmd_data}, 24'h0);
        check("midrst_state", {busy, err_cnt, in0, in1}, 41'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_reset();

        // Randomized traffic against the reference model.
        for (int it = 0; it < 150; it++) begin
            bit pw;
            pw = (predict() < 0);
            if (pw && !near_tick()) begin
                r = $urandom_range(0, 3);
                if (r == 1) out0 = m_sh[0] ^ 16'($urandom_range(1, 65535));
                else if (r == 2) out1 = m_sh[1] ^ 16'($urandom_range(1, 65535));
                else if (r == 3) begin
                    n = $urandom_range(0, 1);
                    if (n == 0) irq0 = 1'b1; else irq1 = 1'b1;
                    m_rf[n] = 1'b1;
                    @(negedge clk);
                    irq0 = 1'b0;
                    irq1 = 1'b0;
                end
            end
            wait_valid(pw ? PERIOD + 50 : 12, got);
            if (!got) break;
            s = predict();
            check("rnd_slot_pending", s >= 0, 1'b1);
            if (s < 0) break;
            check("rnd_cmd", {cmd_addr, cmd_rw, cmd_data},
                  {(s / 2 == 1) ? 7'h21 : 7'h20, s % 2 == 1, (s % 2 == 1) ? 16'h0 : outv(s / 2)});
            wd = cmd_data;
            model_grant(s);
            accept($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) out0 = 16'($urandom);
            if ($urandom_range(0, 2) == 0) out1 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                n = $urandom_range(0, 1);
                if (n == 0) irq0 = 1'b1; else irq1 = 1'b1;
                m_rf[n] = 1'b1;
                @(negedge clk);
                irq0 = 1'b0;
                irq1 = 1'b0;
            end
            repeat ($urandom_range(0, 14)) @(negedge clk);
            while (near_tick()) @(negedge clk);
            e  = ($urandom_range(0, 4) == 0);
            rd = 16'($urandom);
            respond(e, rd);
            model_done(s, wd, rd, e);
            check("rnd_in0", in0, m_in[0]);
            check("rnd_in1", in1, m_in[1]);
            check("rnd_err", err_cnt, m_err);
            check("rnd_upd", {in0_upd, in1_upd}, {s == 1 && !e, s == 3 && !e});
            check("rnd_idle_gap", busy, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
